// File: rtl/muldiv_sequencer.sv
// RV32M multiply/divide sequencer: radix-2 shift-add multiply, restoring divide (option MULDIV_FAST_MUL_EN).
// Latency: Done DATA_W+2 cycles after accept (3 for multiplies with MULDIV_FAST_MUL_EN, 1 for div-by-zero/overflow).
// Backpressure: Stall freezes the pipeline until DONE; Flush aborts any state at once with no Done.
module muldiv_sequencer #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              Start,
    input  logic [2:0]        Funct3,
    input  logic [DATA_W-1:0] SrcA,
    input  logic [DATA_W-1:0] SrcB,
    input  logic              Flush,
    output logic              Stall,
    output logic              Busy,
    output logic              Done,
    output logic [DATA_W-1:0] Result
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t              state, state_nxt;
    logic [2:0]          op;
    logic                neg;
    logic [DATA_W-1:0]   opnd;
    logic [2*DATA_W-1:0] acc;
    logic [CNT_W-1:0]    cnt;

    logic                a_signed, b_signed, a_neg, b_neg, neg_in;
    logic [DATA_W-1:0]   a_abs, b_abs;
    logic                div_zero, div_ovf, accept, last_iter;
    logic [DATA_W-1:0]   special_val;
    logic [DATA_W:0]     mul_sum, div_shift, div_diff;
    logic                no_borrow;
    logic [2*DATA_W-1:0] mul_step, div_step, mul_full;
    logic [DATA_W-1:0]   div_val, div_fix, fix_res;

    // Operand conditioning: magnitudes plus the sign the final result must carry.
    always_comb begin
        a_signed    = Funct3[2] ? ~Funct3[0] : (Funct3[0] ^ Funct3[1]);
        b_signed    = Funct3[2] ? ~Funct3[0] : (Funct3[1:0] == 2'b01);
        a_neg       = a_signed & SrcA[DATA_W-1];
        b_neg       = b_signed & SrcB[DATA_W-1];
        a_abs       = a_neg ? -SrcA : SrcA;
        b_abs       = b_neg ? -SrcB : SrcB;
        neg_in      = (Funct3[2] & Funct3[1]) ? a_neg : (a_neg ^ b_neg);
        div_zero    = Funct3[2] && (SrcB == '0);
        div_ovf     = Funct3[2] && !Funct3[0] && (SrcA == MIN_NEG) && (SrcB == '1);
        if (div_zero)
            special_val = Funct3[1] ? SrcA : '1;
        else
            special_val = Funct3[1] ? '0 : MIN_NEG;
        accept      = (state == IDLE) && Start && !Flush;
`ifdef MULDIV_FAST_MUL_EN
        last_iter   = !op[2] || (cnt == CNT_W'(DATA_W-1));
`else
        last_iter   = (cnt == CNT_W'(DATA_W-1));
`endif
    end

    // One iteration step: acc = {hi, lo}; multiply shifts the product right,
    // divide shifts the dividend out of lo into the partial remainder in hi.
    always_comb begin
        mul_sum   = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, opnd} : '0);
        mul_step  = {mul_sum, acc[DATA_W-1:1]};
        div_shift = acc[2*DATA_W-1:DATA_W-1];
        div_diff  = div_shift - {1'b0, opnd};
        no_borrow = !div_diff[DATA_W];
        div_step  = {(no_borrow ? div_diff[DATA_W-1:0] : div_shift[DATA_W-1:0]),
                     acc[DATA_W-2:0], no_borrow};
        mul_full  = neg ? -acc : acc;
        div_val   = op[1] ? acc[2*DATA_W-1:DATA_W] : acc[DATA_W-1:0];
        div_fix   = neg ? -div_val : div_val;
        if (op[2])
            fix_res = div_fix;
        else if (op[1:0] == 2'b00)
            fix_res = mul_full[DATA_W-1:0];
        else
            fix_res = mul_full[2*DATA_W-1:DATA_W];
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = (div_zero || div_ovf) ? DONE : CALC;
            CALC: if (last_iter) state_nxt = FIX;
            FIX:  state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (Flush)
            state_nxt = IDLE;
        Stall = (accept || state == CALC || state == FIX) && !Flush;
        Busy  = (state != IDLE);
        Done  = (state == DONE) && !Flush;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            op     <= '0;
            neg    <= 1'b0;
            opnd   <= '0;
            acc    <= '0;
            cnt    <= '0;
            Result <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op   <= Funct3;
                neg  <= neg_in;
                opnd <= Funct3[2] ? b_abs : a_abs;
                acc  <= {{DATA_W{1'b0}}, (Funct3[2] ? a_abs : b_abs)};
                cnt  <= '0;
                if (div_zero || div_ovf)
                    Result <= special_val;
            end
            if (state == CALC) begin
                cnt <= cnt + 1'b1;
`ifdef MULDIV_FAST_MUL_EN
                if (!op[2])
                    acc <= {{DATA_W{1'b0}}, opnd} * {{DATA_W{1'b0}}, acc[DATA_W-1:0]};
                else
                    acc <= div_step;
`else
                acc <= op[2] ? div_step : mul_step;
`endif
            end
            if (state == FIX && !Flush)
                Result <= fix_res;
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: expected results queued at issue, checked when Done pulses.
module tb_muldiv_sequencer;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 3;
`else
    localparam int MUL_LAT = 34;
`endif
    localparam int DIV_LAT = 34;

    logic        clk = 1'b0;
    logic        reset;
    logic        Start;
    logic [2:0]  Funct3;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        Flush;
    logic        Stall;
    logic        Busy;
    logic        Done;
    logic [31:0] Result;

    int          n_cmp = 0;
    int          n_err = 0;
    int          done_cnt = 0;
    logic [31:0] exp_q[$];
    longint      done_t[$];
    logic [31:0] last_exp = 32'h0;

    muldiv_sequencer #(.DATA_W(32)) dut (
        .clk(clk), .reset(reset), .Start(Start), .Funct3(Funct3),
        .SrcA(SrcA), .SrcB(SrcB), .Flush(Flush), .Stall(Stall),
        .Busy(Busy), .Done(Done), .Result(Result)
    );

    always #5 clk = ~clk;

    always begin
        @(negedge clk);
        #2;
        if (Done === 1'b1) begin
            done_cnt++;
            done_t.push_back($time);
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the op already presented; returns #1 after the negedge of the Done cycle.
    task automatic wait_done(input string tag, output int cyc, output bit stall_ok);
        logic [31:0] exp;
        cyc = 0;
        stall_ok = 1'b1;
        #1;
        while (Done !== 1'b1 && cyc < 200) begin
            if (Stall !== 1'b1) stall_ok = 1'b0;
            @(negedge clk);
            #1;
            cyc++;
        end
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        chk({tag, "_done"}, {31'b0, Done}, 32'd1);
        chk({tag, "_result"}, Result, exp);
        last_exp = exp;
    endtask

    // Start is held through the DONE cycle and dropped in the following IDLE cycle.
    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat);
        int cyc;
        bit sok;
        Funct3 = f3;
        SrcA   = a;
        SrcB   = b;
        Start  = 1'b1;
        exp_q.push_back(exp);
        wait_done(tag, cyc, sok);
        chk({tag, "_latency"}, cyc, lat);
        chk({tag, "_stall_held"}, {31'b0, sok}, 32'd1);
        chk({tag, "_stall_in_done"}, {31'b0, Stall}, 32'd0);
        @(negedge clk);
        Start = 1'b0;
    endtask

    initial begin
        int d0;
        int cyc;
        bit sok;
        reset  = 1'b1;
        Start  = 1'b0;
        Flush  = 1'b0;
        Funct3 = 3'b000;
        SrcA   = 32'h0;
        SrcB   = 32'h0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("reset_busy", {31'b0, Busy}, 32'd0);
        chk("reset_stall", {31'b0, Stall}, 32'd0);
        chk("reset_done", {31'b0, Done}, 32'd0);
        chk("reset_result", Result, 32'h0);
        @(negedge clk);

        run_op("mul_7xm3",      3'b000, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT);
        run_op("mulhu_max",     3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT);
        run_op("mulh_min",      3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT);
        run_op("mulhsu_m1",     3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT);
        run_op("mulh_m1",       3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, MUL_LAT);
        run_op("div_m7_2",      3'b100, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, DIV_LAT);
        run_op("rem_m7_2",      3'b110, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, DIV_LAT);
        run_op("div_7_m2",      3'b100, 32'd7,        32'hFFFF_FFFE, 32'hFFFF_FFFD, DIV_LAT);
        run_op("rem_7_m2",      3'b110, 32'd7,        32'hFFFF_FFFE, 32'd1,        DIV_LAT);
        run_op("divu_100_7",    3'b101, 32'd100,      32'd7,        32'd14,       DIV_LAT);
        run_op("remu_100_7",    3'b111, 32'd100,      32'd7,        32'd2,        DIV_LAT);
        run_op("div_5_0",       3'b100, 32'd5,        32'd0,        32'hFFFF_FFFF, 1);
        run_op("rem_5_0",       3'b110, 32'd5,        32'd0,        32'd5,        1);
        run_op("divu_5_0",      3'b101, 32'd5,        32'd0,        32'hFFFF_FFFF, 1);
        run_op("remu_5_0",      3'b111, 32'd5,        32'd0,        32'd5,        1);
        run_op("div_ovf",       3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("rem_ovf",       3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,        1);
        run_op("divu_min_max",  3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,        DIV_LAT);

        // Start held high through DONE must produce a single Done.
        d0 = done_cnt;
        run_op("divu_hold",     3'b101, 32'd1000,     32'd10,       32'd100,      DIV_LAT);
        repeat (40) @(negedge clk);
        chk("hold_one_done", done_cnt - d0, 32'd1);

        // Flush mid-divide at cycle 10.
        d0 = done_cnt;
        Funct3 = 3'b101;
        SrcA   = 32'd12345;
        SrcB   = 32'd3;
        Start  = 1'b1;
        repeat (10) @(negedge clk);
        Flush = 1'b1;
        #1;
        chk("flush_stall_same_cycle", {31'b0, Stall}, 32'd0);
        chk("flush_done_same_cycle", {31'b0, Done}, 32'd0);
        @(negedge clk);
        Start = 1'b0;
        Flush = 1'b0;
        #1;
        chk("flush_stall_next", {31'b0, Stall}, 32'd0);
        chk("flush_busy_next", {31'b0, Busy}, 32'd0);
        repeat (40) @(negedge clk);
        chk("flush_no_done", done_cnt - d0, 32'd0);
        chk("flush_result_kept", Result, last_exp);

        // Start and Flush together in IDLE: nothing accepted.
        Funct3 = 3'b000;
        SrcA   = 32'd3;
        SrcB   = 32'd4;
        Start  = 1'b1;
        Flush  = 1'b1;
        #1;
        chk("startflush_stall", {31'b0, Stall}, 32'd0);
        @(negedge clk);
        Start = 1'b0;
        Flush = 1'b0;
        #1;
        chk("startflush_busy", {31'b0, Busy}, 32'd0);
        @(negedge clk);

        // Reset in the middle of an operation.
        d0 = done_cnt;
        Funct3 = 3'b100;
        SrcA   = 32'd999;
        SrcB   = 32'd9;
        Start  = 1'b1;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        Start = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midreset_busy", {31'b0, Busy}, 32'd0);
        chk("midreset_result", Result, 32'h0);
        repeat (40) @(negedge clk);
        chk("midreset_no_done", done_cnt - d0, 32'd0);

        // Back-to-back: Start dropped only during the DONE cycle.
        done_t.delete();
        Funct3 = 3'b101;
        SrcA   = 32'd100;
        SrcB   = 32'd7;
        Start  = 1'b1;
        exp_q.push_back(32'd14);
        wait_done("b2b_first", cyc, sok);
        chk("b2b_first_latency", cyc, DIV_LAT);
        Start = 1'b0;
        @(negedge clk);
        Funct3 = 3'b111;
        Start  = 1'b1;
        exp_q.push_back(32'd2);
        wait_done("b2b_second", cyc, sok);
        chk("b2b_second_latency", cyc, DIV_LAT);
        chk("b2b_second_stall", {31'b0, sok}, 32'd1);
        @(negedge clk);
        Start = 1'b0;
        repeat (3) @(negedge clk);
        chk("b2b_done_count", done_t.size(), 32'd2);
        chk("b2b_done_gap", (done_t.size() == 2) ? 32'(done_t[1] - done_t[0]) : 32'd0, 32'd350);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
